debounce_multi: RTL
===================

# debounce_multi

Parametrised multi-channel debouncer with a shared sample prescaler and symmetric hysteresis. Each channel must see `SAMPLES` consecutive, agreeing, slow-rate samples before its output changes, in either direction. It sits between board-level pushbuttons, switches or reset pins and the core logic. It runs on the raw board clock, so it needs no divided clock and can itself feed the clock-division reset path.

## Interface
Parameters:
- `N`, 4: number of independent channels.
- `TICK_DIV`, 64: clock cycles per sample tick (≥1).
- `SAMPLES`, 3: consecutive differing samples required to flip an output (≥1).
- `ACTIVE_LOW`, 1: when 1, `din` is inverted before sampling, so a low pin reads as asserted.

Ports:
- `clk`, in, 1: single system clock. All state is on the rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `din`, in, N: raw, possibly bouncing inputs. Already synchronised to `clk` upstream.
- `dout`, out, N: debounced level, active-high.
- `rise`, out, N: one-cycle pulse when `dout[i]` goes 0→1.
- `fall`, out, N: one-cycle pulse when `dout[i]` goes 1→0.
- `tick`, out, 1: high for the one cycle in which samples are taken.

## Operation
- Prescaler `div_cnt`, width `$clog2(TICK_DIV)` (minimum 1), counts 0..TICK_DIV-1 and then wraps to 0.
  - `tick = (div_cnt == TICK_DIV-1)`, decoded from the registered count.
  - With `TICK_DIV=1`, `tick` is constantly 1 after reset.
- Per channel i: `s = din[i] ^ ACTIVE_LOW`. A stability counter `cnt`, width `$clog2(SAMPLES+1)`, updates only when `tick=1`:
  - `s == dout[i]`: `cnt <= 0` (any agreeing sample cancels progress).
  - `s != dout[i]` and `cnt == SAMPLES-1`: `dout[i] <= s`, `cnt <= 0`, and `rise[i]`/`fall[i] <= 1` according to `s`.
  - Otherwise: `cnt <= cnt + 1`.
- When `tick=0`, `cnt` and `dout` hold, and `rise`/`fall` are 0.
- `rise`/`fall` are registered, never both high, and never high for two consecutive cycles.
- Channels are fully independent; simultaneous flips on several channels are legal.
- Reset (`reset_n=0` at a clock edge): `div_cnt=0`, all `cnt=0`, `dout=0`, `rise=0`, `fall=0`. `tick=0` unless `TICK_DIV=1`. Reset asserted mid-count discards partial progress. Held reset forces outputs to 0 regardless of `din`.

## Timing
- Sample capture happens on the edge that ends a `tick` cycle. `dout`, `rise` and `fall` change on that same edge and are visible the next cycle.
- First tick after reset release: cycle `TICK_DIV-1`, counting the release cycle as cycle 0.
- Worst-case latency from a stable input change to `dout`: `SAMPLES*TICK_DIV` cycles. Best case: `(SAMPLES-1)*TICK_DIV+1`.
- Glitches shorter than `TICK_DIV` cycles can never flip an output when `SAMPLES ≥ 2`.

## Configuration
- `DEBOUNCE_EDGE_EN` defined: `rise`/`fall` behave as specified above.
- `DEBOUNCE_EDGE_EN` undefined: `rise`/`fall` ports remain present but are tied to 0, and no edge registers are synthesised.
- All other behaviour is identical in both builds.

## Structure
- Shared package `db_pkg`: default constants `DB_TICK_DIV_DEF=64`, `DB_SAMPLES_DEF=3`, plus a `clog2` helper function used for the counter widths.
- Sub-module `debounce_channel`: holds `cnt`, `dout`, `rise` and `fall` for one bit, with inputs `clk`, `reset_n`, `tick` and `s`. It is instantiated N times in a generate loop. The prescaler lives in the top level.

## Test plan
All scenarios use N=2, TICK_DIV=4, SAMPLES=3, ACTIVE_LOW=1.
1. Hold `reset_n=0` for 10 cycles with `din=2'b00` → `dout=0`, `rise=fall=0`. After release, `tick` is first high in cycle 3, then in cycles 7, 11, ….
2. `din[0]=0` held from release → `dout[0]=1` from cycle 12, with `rise[0]` high only in cycle 12. `dout[1]` also rises in cycle 12, since `din[1]=0` too.
3. With `dout[1]=1` and `din[1]=1`, drive `din[1]=0` for 6 cycles spanning one tick → `dout[1]` stays 1 and `fall[1]` stays 0.
4. Set `din[0]=1` just after a tick → `dout[0]=0` exactly 12 cycles later, with a single `fall[0]` pulse.
5. Per-tick sample pattern on channel 0 (asserted = `din[0]` low): asserted, released, asserted, asserted, asserted → `dout[0]` flips only on the 5th tick, because the released sample cleared `cnt`.
6. Assert `reset_n=0` for one cycle while `dout=2'b11` and `div_cnt=2` → next cycle `dout=0` and `div_cnt=0`. The next tick arrives 3 cycles after release, and flips again require 3 full ticks.

Source files
------------

// File: rtl/db_pkg.sv
// Shared constants and width helper for the multi-channel debouncer.
package db_pkg;

  localparam int DB_TICK_DIV_DEF = 64;
  localparam int DB_SAMPLES_DEF  = 3;

  // Ceiling log2 with a floor of 1, so a counter is never zero bits wide.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: stability counter, debounced level and edge pulses.
// Edge registers exist only when DEBOUNCE_EDGE_EN is defined; otherwise
// rise/fall are tied low.
module debounce_channel
  import db_pkg::*;
#(
  parameter int SAMPLES = DB_SAMPLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic s,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CW = clog2(SAMPLES + 1);

  logic [CW-1:0] cnt;
  logic          flip;

  // A flip happens on the tick that delivers the last of SAMPLES disagreeing samples.
  assign flip = tick && (s != dout) && (cnt == CW'(SAMPLES - 1));

  // Stability counter and debounced level; any agreeing sample cancels progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (tick) begin
      if (s == dout) begin
        cnt <= '0;
      end else if (flip) begin
        dout <= s;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  // Single-cycle edge pulses, registered alongside the level change.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= flip && s;
      fall <= flip && !s;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer with a shared sample prescaler.
// Optional feature macro: DEBOUNCE_EDGE_EN enables the rise/fall pulses.
module debounce_multi
  import db_pkg::*;
#(
  parameter int N          = 4,
  parameter int TICK_DIV   = DB_TICK_DIV_DEF,
  parameter int SAMPLES    = DB_SAMPLES_DEF,
  parameter int ACTIVE_LOW = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         tick
);

  localparam int DW = clog2(TICK_DIV);

  logic [DW-1:0] div_cnt;
  logic          pol;

  assign pol  = (ACTIVE_LOW != 0);
  // Decoded from the registered count; with TICK_DIV=1 the count stays 0 and tick is always high.
  assign tick = (div_cnt == DW'(TICK_DIV - 1));

  // Prescaler counts 0..TICK_DIV-1 and wraps on the tick cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_channel #(
      .SAMPLES(SAMPLES)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .s      (din[i] ^ pol),
      .dout   (dout[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

endmodule
